// File: rtl/ysyx_22051013_trap_ctrl.sv
// Trap/CSR sequencer: handles ecall, mret, CSR access and (optionally) timer interrupts at commit.
// Optional feature macro: YSYX_22051013_TIMER_IRQ_EN enables the timer interrupt path.
module ysyx_22051013_trap_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_ecall,
   input  logic        ex_mret,
   input  logic        ex_csr_wr,
   input  logic        ex_csr_rd,
   input  logic [63:0] ex_pc,
   input  logic [11:0] ex_csr_addr,
   input  logic [63:0] ex_csr_wdata,
   input  logic        timer_irq,
   input  logic        mstatus_mie,
   input  logic [63:0] csr_rdata,
   output logic [3:0]  csr_ctl,
   output logic [11:0] csr_addr,
   output logic [63:0] write_csr_data,
   output logic [63:0] mcause_value,
   output logic        stall,
   output logic        flush,
   output logic        redirect_valid,
   output logic [63:0] redirect_pc,
   output logic        csr_done,
   output logic [63:0] csr_result
);

   localparam int unsigned XLEN  = 64;
   localparam int unsigned AW    = 12;
   localparam int unsigned CTLW  = 4;

   localparam logic [XLEN-1:0] CAUSE_IRQ   = 64'h8000_0000_0000_0007;
   localparam logic [XLEN-1:0] CAUSE_ECALL = 64'd11;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SAVE = 3'd1,
      RET  = 3'd2,
      CSR  = 3'd3,
      JUMP = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, wdata_q, cause_q, target_q, result_q;
   logic [AW-1:0]   addr_q;
   logic            wr_q, rd_q;
   logic            irq_take;
   logic            evt;
   logic            take_evt;

`ifdef YSYX_22051013_TIMER_IRQ_EN
   assign irq_take = timer_irq & mstatus_mie;
`else
   logic unused_irq;
   assign irq_take   = 1'b0;
   assign unused_irq = timer_irq ^ mstatus_mie;
`endif

   // Gating with rst keeps stall low while reset is held.
   assign evt = rst & ex_valid & (irq_take | ex_ecall | ex_mret | ex_csr_wr | ex_csr_rd);

   assign csr_result = result_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      take_evt       = 1'b0;
      stall          = 1'b0;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      csr_done       = 1'b0;
      csr_ctl        = '0;
      csr_addr       = '0;
      write_csr_data = '0;
      mcause_value   = '0;
      case (state_q)
         IDLE: begin
            if (evt) begin
               stall    = 1'b1;
               take_evt = 1'b1;
               if (irq_take || ex_ecall) begin
                  state_d = SAVE;
               end else if (ex_mret) begin
                  state_d = RET;
               end else begin
                  state_d = CSR;
               end
            end
         end
         SAVE: begin
            stall          = 1'b1;
            csr_ctl        = CTLW'(4'b0010);
            write_csr_data = pc_q;
            mcause_value   = cause_q;
            state_d        = JUMP;
         end
         RET: begin
            stall   = 1'b1;
            csr_ctl = CTLW'(4'b0001);
            state_d = JUMP;
         end
         CSR: begin
            stall          = 1'b1;
            csr_ctl        = {wr_q, rd_q, 2'b00};
            csr_addr       = addr_q;
            write_csr_data = wdata_q;
            state_d        = DONE;
         end
         JUMP: begin
            stall          = 1'b1;
            flush          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = target_q;
            state_d        = IDLE;
         end
         DONE: begin
            csr_done = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand latches, trap target and CSR read result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cause_q  <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         target_q <= '0;
         result_q <= '0;
      end else begin
         if (take_evt) begin
            pc_q    <= ex_pc;
            addr_q  <= ex_csr_addr;
            wdata_q <= ex_csr_wdata;
            wr_q    <= ex_csr_wr;
            rd_q    <= ex_csr_rd;
            if (irq_take) begin
               cause_q <= CAUSE_IRQ;
            end else if (ex_ecall) begin
               cause_q <= CAUSE_ECALL;
            end else begin
               cause_q <= '0;
            end
         end
         if (state_q == SAVE || state_q == RET) begin
            target_q <= csr_rdata;
         end
         if (state_q == CSR) begin
            result_q <= csr_rdata;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22051013_trap_ctrl.sv
// Directed self-checking bench for ysyx_22051013_trap_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_ysyx_22051013_trap_ctrl;

   logic        clk;
   logic        rst;
   logic        ex_valid, ex_ecall, ex_mret, ex_csr_wr, ex_csr_rd;
   logic [63:0] ex_pc;
   logic [11:0] ex_csr_addr;
   logic [63:0] ex_csr_wdata;
   logic        timer_irq, mstatus_mie;
   logic [63:0] csr_rdata;
   logic [3:0]  csr_ctl;
   logic [11:0] csr_addr;
   logic [63:0] write_csr_data, mcause_value;
   logic        stall, flush, redirect_valid, csr_done;
   logic [63:0] redirect_pc, csr_result;

   int n_chk  = 0;
   int n_pass = 0;

   ysyx_22051013_trap_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .ex_valid       (ex_valid),
      .ex_ecall       (ex_ecall),
      .ex_mret        (ex_mret),
      .ex_csr_wr      (ex_csr_wr),
      .ex_csr_rd      (ex_csr_rd),
      .ex_pc          (ex_pc),
      .ex_csr_addr    (ex_csr_addr),
      .ex_csr_wdata   (ex_csr_wdata),
      .timer_irq      (timer_irq),
      .mstatus_mie    (mstatus_mie),
      .csr_rdata      (csr_rdata),
      .csr_ctl        (csr_ctl),
      .csr_addr       (csr_addr),
      .write_csr_data (write_csr_data),
      .mcause_value   (mcause_value),
      .stall          (stall),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .csr_done       (csr_done),
      .csr_result     (csr_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clear_ex();
      ex_valid     = 1'b0;
      ex_ecall     = 1'b0;
      ex_mret      = 1'b0;
      ex_csr_wr    = 1'b0;
      ex_csr_rd    = 1'b0;
      ex_pc        = '0;
      ex_csr_addr  = '0;
      ex_csr_wdata = '0;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_ctl"},   64'(csr_ctl), 64'd0);
      chk({tag, "_stall"}, 64'(stall), 64'd0);
      chk({tag, "_rv"},    64'(redirect_valid), 64'd0);
      chk({tag, "_flush"}, 64'(flush), 64'd0);
      chk({tag, "_done"},  64'(csr_done), 64'd0);
   endtask

   initial begin
      rst         = 1'b0;
      timer_irq   = 1'b0;
      mstatus_mie = 1'b0;
      csr_rdata   = '0;
      clear_ex();

      // Reset state
      #3;
      chk_quiet("rst");
      chk("rst_wdata",  write_csr_data, 64'd0);
      chk("rst_cause",  mcause_value, 64'd0);
      chk("rst_rpc",    redirect_pc, 64'd0);
      chk("rst_result", csr_result, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_quiet("post_rst");

      // ecall at 0x8000_0010, mtvec 0x8000_0100
      ex_valid = 1'b1; ex_ecall = 1'b1; ex_pc = 64'h8000_0010;
      #1;
      chk("ecall_stall_n", 64'(stall), 64'd1);
      chk("ecall_ctl_n",   64'(csr_ctl), 64'd0);
      @(negedge clk);
      clear_ex();
      csr_rdata = 64'h8000_0100;
      chk("ecall_save_ctl",   64'(csr_ctl), 64'h2);
      chk("ecall_save_pc",    write_csr_data, 64'h8000_0010);
      chk("ecall_save_cause", mcause_value, 64'd11);
      chk("ecall_save_stall", 64'(stall), 64'd1);
      chk("ecall_save_rv",    64'(redirect_valid), 64'd0);
      @(negedge clk);
      csr_rdata = '0;
      chk("ecall_jump_rv",    64'(redirect_valid), 64'd1);
      chk("ecall_jump_pc",    redirect_pc, 64'h8000_0100);
      chk("ecall_jump_flush", 64'(flush), 64'd1);
      chk("ecall_jump_stall", 64'(stall), 64'd1);
      chk("ecall_jump_ctl",   64'(csr_ctl), 64'd0);
      @(negedge clk);
      chk_quiet("ecall_after");

      // mret with mepc 0x8000_0014
      ex_valid = 1'b1; ex_mret = 1'b1; ex_pc = 64'h8000_0050;
      #1;
      chk("mret_stall_n", 64'(stall), 64'd1);
      @(negedge clk);
      clear_ex();
      csr_rdata = 64'h8000_0014;
      chk("mret_ret_ctl",   64'(csr_ctl), 64'h1);
      chk("mret_ret_stall", 64'(stall), 64'd1);
      chk("mret_ret_cause", mcause_value, 64'd0);
      @(negedge clk);
      csr_rdata = '0;
      chk("mret_jump_rv",    64'(redirect_valid), 64'd1);
      chk("mret_jump_pc",    redirect_pc, 64'h8000_0014);
      chk("mret_jump_flush", 64'(flush), 64'd1);
      @(negedge clk);
      chk("mret_flush_once", 64'(flush), 64'd0);
      chk("mret_rv_once",    64'(redirect_valid), 64'd0);

      // csrrs read of 0x300 returning 0x1800; DONE ignores a concurrent ecall
      ex_valid = 1'b1; ex_csr_rd = 1'b1; ex_csr_addr = 12'h300;
      @(negedge clk);
      clear_ex();
      csr_rdata = 64'h1800;
      chk("csrr_ctl",  64'(csr_ctl), 64'h4);
      chk("csrr_addr", 64'(csr_addr), 64'h300);
      @(negedge clk);
      csr_rdata = 64'hdead;
      ex_valid = 1'b1; ex_ecall = 1'b1; ex_pc = 64'h8000_0090;
      #1;
      chk("csrr_done",   64'(csr_done), 64'd1);
      chk("csrr_result", csr_result, 64'h1800);
      chk("csrr_stall",  64'(stall), 64'd0);
      @(negedge clk);
      chk("done_ign_ctl",   64'(csr_ctl), 64'd0);
      chk("done_ign_cause", mcause_value, 64'd0);
      clear_ex();
      @(negedge clk);
      chk("csrr_hold", csr_result, 64'h1800);
      chk("csrr_quiet_ctl", 64'(csr_ctl), 64'd0);

      // csrrw 0x305 <= 0x8000_0200, old value 0
      ex_valid = 1'b1; ex_csr_wr = 1'b1; ex_csr_rd = 1'b1;
      ex_csr_addr = 12'h305; ex_csr_wdata = 64'h8000_0200;
      #1;
      chk("csrrw_stall_n", 64'(stall), 64'd1);
      @(negedge clk);
      clear_ex();
      csr_rdata = 64'd0;
      chk("csrrw_ctl",   64'(csr_ctl), 64'hc);
      chk("csrrw_addr",  64'(csr_addr), 64'h305);
      chk("csrrw_wdata", write_csr_data, 64'h8000_0200);
      chk("csrrw_stall", 64'(stall), 64'd1);
      @(negedge clk);
      chk("csrrw_done",   64'(csr_done), 64'd1);
      chk("csrrw_result", csr_result, 64'd0);
      chk("csrrw_rv",     64'(redirect_valid), 64'd0);
      @(negedge clk);
      chk("csrrw_done_once", 64'(csr_done), 64'd0);

`ifdef YSYX_22051013_TIMER_IRQ_EN
      // Interrupt beats a concurrent ecall
      timer_irq = 1'b1; mstatus_mie = 1'b1;
      ex_valid = 1'b1; ex_ecall = 1'b1; ex_pc = 64'h8000_0020;
      @(negedge clk);
      clear_ex();
      timer_irq = 1'b0; mstatus_mie = 1'b0;
      csr_rdata = 64'h8000_0100;
      chk("irq_cause", mcause_value, 64'h8000_0000_0000_0007);
      chk("irq_pc",    write_csr_data, 64'h8000_0020);
      chk("irq_ctl",   64'(csr_ctl), 64'h2);
      @(negedge clk);
      chk("irq_jump_pc", redirect_pc, 64'h8000_0100);
      @(negedge clk);
      // mie=0 masks the interrupt, ecall is taken
      timer_irq = 1'b1; mstatus_mie = 1'b0;
      ex_valid = 1'b1; ex_ecall = 1'b1; ex_pc = 64'h8000_0020;
      @(negedge clk);
      clear_ex();
      timer_irq = 1'b0;
      chk("irqmask_cause", mcause_value, 64'd11);
      @(negedge clk);
      @(negedge clk);
      csr_rdata = '0;
`else
      // Interrupt path compiled out: no event without an instruction
      timer_irq = 1'b1; mstatus_mie = 1'b1; ex_valid = 1'b1; ex_pc = 64'h8000_0030;
      #1;
      chk("noirq_stall_n", 64'(stall), 64'd0);
      @(negedge clk);
      chk_quiet("noirq_n1");
      @(negedge clk);
      chk_quiet("noirq_n2");
      // ecall with a pending timer still reports cause 11
      ex_ecall = 1'b1;
      @(negedge clk);
      clear_ex();
      csr_rdata = 64'h8000_0100;
      chk("noirq_ecall_cause", mcause_value, 64'd11);
      chk("noirq_ecall_pc",    write_csr_data, 64'h8000_0030);
      @(negedge clk);
      chk("noirq_jump_pc", redirect_pc, 64'h8000_0100);
      @(negedge clk);
      timer_irq = 1'b0; mstatus_mie = 1'b0; csr_rdata = '0;
`endif

      // Reset in SAVE aborts the trap
      ex_valid = 1'b1; ex_ecall = 1'b1; ex_pc = 64'h8000_0040;
      @(negedge clk);
      clear_ex();
      csr_rdata = 64'h8000_0400;
      chk("abort_save_ctl", 64'(csr_ctl), 64'h2);
      rst = 1'b0;
      #1;
      chk_quiet("abort_rst");
      chk("abort_rst_wdata", write_csr_data, 64'd0);
      chk("abort_rst_cause", mcause_value, 64'd0);
      chk("abort_rst_rpc",   redirect_pc, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_quiet("abort_c1");
      chk("abort_c1_rpc", redirect_pc, 64'd0);
      @(negedge clk);
      chk_quiet("abort_c2");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ysyx_22051013_trap_ctrl.md
YSYX_22051013_TRAP_CTRL -- requirements
Module: ysyx_22051013_trap_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports ex_valid, ex_ecall, ex_mret, ex_csr_wr, ex_csr_rd  input  1 each  commit-stage valid and decoded instruction class.
REQ-004 SHALL have ports ex_pc  input  64  and ex_csr_addr  input  12  and ex_csr_wdata  input  64  (commit-stage operands).
REQ-005 SHALL have ports timer_irq  input  1  (level) and mstatus_mie  input  1  (from CSR file).
REQ-006 SHALL have port csr_rdata  input  64  (CSR file combinational read data).
REQ-007 SHALL have outputs csr_ctl  4  {wr,rd,ecall,mret}; csr_addr  12; write_csr_data  64; mcause_value  64 (to CSR file).
REQ-008 SHALL have outputs stall  1; flush  1; redirect_valid  1; redirect_pc  64; csr_done  1; csr_result  64.

Function
REQ-009 SHALL implement FSM states IDLE, SAVE, RET, CSR, JUMP, DONE.
REQ-010 In IDLE, event = ex_valid & (irq_take | ex_ecall | ex_mret | ex_csr_wr | ex_csr_rd); stall SHALL equal event combinationally.
REQ-011 irq_take SHALL equal timer_irq & mstatus_mie.
REQ-012 Priority SHALL be irq_take > ex_ecall > ex_mret > CSR access; the lower-priority event is dropped.
REQ-013 On event, SHALL latch ex_pc, ex_csr_addr, ex_csr_wdata, and cause: 64'h8000_0000_0000_0007 for irq, 64'd11 for ecall.
REQ-014 IDLE->SAVE on irq/ecall; ->RET on mret; ->CSR on csr access.
REQ-015 SAVE (1 cycle) SHALL drive csr_ctl=4'b0010, write_csr_data=latched pc, mcause_value=latched cause, and capture csr_rdata (mtvec) as target; ->JUMP.
REQ-016 RET (1 cycle) SHALL drive csr_ctl=4'b0001 and capture csr_rdata (mepc) as target; ->JUMP.
REQ-017 CSR (1 cycle) SHALL drive csr_ctl={wr,rd,2'b00}, csr_addr=latched addr, write_csr_data=latched wdata, and capture csr_rdata into csr_result; ->DONE.
REQ-018 JUMP (1 cycle) SHALL assert redirect_valid=1, flush=1, redirect_pc=target, stall=1; ->IDLE.
REQ-019 DONE (1 cycle) SHALL assert csr_done=1, stall=0, ignore ex inputs; ->IDLE.
REQ-020 stall SHALL be 1 in SAVE, RET, CSR, JUMP.
REQ-021 csr_ctl SHALL be 4'b0000 in IDLE, JUMP, DONE.
REQ-022 mepc saved for irq SHALL be the pc of the interrupted, not-executed instruction; no +4 applied.
REQ-023 Latency: ecall/irq/mret event cycle N -> redirect_valid at N+2; CSR access -> csr_done at N+2.
REQ-024 csr_result SHALL hold its value until the next CSR-state capture.

Reset
REQ-025 On rst low, SHALL asynchronously enter IDLE and clear all latches, target and csr_result to 0.
REQ-026 All outputs SHALL be 0 during and immediately after reset.
REQ-027 Reset asserted in any state SHALL abort the sequence with no redirect and no csr_done.

Configuration
REQ-028 Macro YSYX_22051013_TIMER_IRQ_EN defined: timer interrupt path per REQ-011..013 is active.
REQ-029 Macro undefined: irq_take is constant 0, timer_irq is unused, and only cause 11 is generated.

Verification
REQ-030 ecall at pc=0x8000_0010, CSR file mtvec=0x8000_0100 -> SAVE csr_ctl=0010, write_csr_data=0x8000_0010, mcause_value=11; redirect_pc=0x8000_0100 two cycles later.
REQ-031 mret with mepc=0x8000_0014 -> RET csr_ctl=0001; redirect_valid with redirect_pc=0x8000_0014 at N+2, flush=1 for one cycle.
REQ-032 csrrw addr=0x305, wdata=0x8000_0200, old value 0 -> CSR csr_ctl=1100, csr_addr=0x305; csr_done=1 and csr_result=0 at N+2.
REQ-033 (macro on) timer_irq=1, mstatus_mie=1, concurrent ecall at pc=0x8000_0020 -> mcause_value=0x8000_0000_0000_0007, saved pc=0x8000_0020, ecall dropped; with mstatus_mie=0 -> ecall taken, mcause_value=11.
REQ-034 rst low during SAVE -> state IDLE immediately; outputs 0; no redirect_valid on the following cycles.
REQ-035 (macro off) timer_irq=1, mstatus_mie=1, ex_valid=1 with no instruction event -> stall=0 and state stays IDLE.
